// File: rtl/charram_dram_sequencer_if.sv
// Bus bundle between the character-RAM sequencer, its clients (video fetch, CPU glue)
// and the 4416 DRAM. The sequencer uses the slave view; clients and the DRAM model use the master view.
interface charram_dram_sequencer_if;
    logic [13:0] vid_addr;
    logic [3:0]  vid_dout;
    logic        vid_valid;

    logic        cpu_req;
    logic        cpu_wr;
    logic [13:0] cpu_addr;
    logic [3:0]  cpu_din;
    logic [3:0]  cpu_dout;
    logic        cpu_ack;

    logic [7:0]  dram_addr;
    logic [3:0]  dram_din;
    logic [3:0]  dram_dout;
    logic        ras_n;
    logic        cas_n;
    logic        wr_n;
    logic        rd_n;

    modport slave (
        input  vid_addr,
        input  cpu_req,
        input  cpu_wr,
        input  cpu_addr,
        input  cpu_din,
        input  dram_dout,
        output vid_dout,
        output vid_valid,
        output cpu_dout,
        output cpu_ack,
        output dram_addr,
        output dram_din,
        output ras_n,
        output cas_n,
        output wr_n,
        output rd_n
    );

    modport master (
        output vid_addr,
        output cpu_req,
        output cpu_wr,
        output cpu_addr,
        output cpu_din,
        output dram_dout,
        input  vid_dout,
        input  vid_valid,
        input  cpu_dout,
        input  cpu_ack,
        input  dram_addr,
        input  dram_din,
        input  ras_n,
        input  cas_n,
        input  wr_n,
        input  rd_n
    );
endinterface

// File: rtl/charram_dram_sequencer.sv
// 16-cycle frame sequencer for one 4416 character-RAM plane: half 0 serves video,
// half 1 serves the CPU or a RAS-only refresh. All DRAM strobes and data outputs are registered.
module charram_dram_sequencer #(
    parameter int unsigned REFRESH_MAX = 16
) (
    input  logic                    mclk_i,
    input  logic                    rst_i,
    charram_dram_sequencer_if.slave bus
);
    localparam int unsigned           STREAK_W     = $clog2(REFRESH_MAX + 1);
    localparam logic [STREAK_W-1:0]   STREAK_LIMIT = STREAK_W'(REFRESH_MAX);

    typedef enum logic [1:0] {
        SLOT_VID    = 2'd0,
        SLOT_CPU_RD = 2'd1,
        SLOT_CPU_WR = 2'd2,
        SLOT_REF    = 2'd3
    } slot_e;

    logic [3:0]          cnt_q, cnt_d;
    slot_e               slot_q, slot_d;
    logic [7:0]          row_q, row_d;
    logic [5:0]          col_q, col_d;
    logic [3:0]          wdat_q, wdat_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [7:0]          ref_row_q, ref_row_d;

    logic                ras_n_q, ras_n_d;
    logic                cas_n_q, cas_n_d;
    logic                wr_n_q, wr_n_d;
    logic                rd_n_q, rd_n_d;
    logic [7:0]          addr_q, addr_d;
    logic [3:0]          din_q, din_d;
    logic [3:0]          vid_dout_q, vid_dout_d;
    logic                vid_valid_q, vid_valid_d;
    logic [3:0]          cpu_dout_q, cpu_dout_d;
    logic                cpu_ack_q, cpu_ack_d;

    logic [2:0]          ph_cur_s;
    logic [2:0]          ph_nxt_s;
    logic                grant_s;
    logic [7:0]          preview_row_s;
    logic [7:0]          col_addr_s;

    assign ph_cur_s   = cnt_q[2:0];
    assign ph_nxt_s   = cnt_d[2:0];
    assign grant_s    = bus.cpu_req && (streak_q < STREAK_LIMIT);
    assign col_addr_s = {1'b0, col_d, 1'b0};

    // Slot latch at PH0, CPU streak bookkeeping and refresh row advance
    always_comb begin
        cnt_d     = cnt_q + 4'd1;
        slot_d    = slot_q;
        row_d     = row_q;
        col_d     = col_q;
        wdat_d    = wdat_q;
        streak_d  = streak_q;
        ref_row_d = ref_row_q;
        if (ph_cur_s == 3'd0) begin
            if (!cnt_q[3]) begin
                slot_d = SLOT_VID;
                row_d  = bus.vid_addr[7:0];
                col_d  = bus.vid_addr[13:8];
            end else if (grant_s) begin
                slot_d   = bus.cpu_wr ? SLOT_CPU_WR : SLOT_CPU_RD;
                row_d    = bus.cpu_addr[7:0];
                col_d    = bus.cpu_addr[13:8];
                wdat_d   = bus.cpu_din;
                // grant implies streak < limit, so this never passes the limit
                streak_d = streak_q + STREAK_W'(1);
            end else begin
                slot_d   = SLOT_REF;
                row_d    = ref_row_q;
                streak_d = '0;
            end
        end else if ((ph_nxt_s == 3'd6) && (slot_q == SLOT_REF)) begin
            ref_row_d = ref_row_q + 8'd1;
        end else begin
            ref_row_d = ref_row_q;
        end
    end

    // Row shown during PH0 is a look-ahead using the same rule as the PH0 latch
    always_comb begin
        preview_row_s = ref_row_q;
        if (!cnt_d[3]) begin
            preview_row_s = bus.vid_addr[7:0];
        end else if (grant_s) begin
            preview_row_s = bus.cpu_addr[7:0];
        end else begin
            preview_row_s = ref_row_q;
        end
    end

    // Next registered strobe/address/data values for the phase being entered
    always_comb begin
        ras_n_d     = 1'b1;
        cas_n_d     = 1'b1;
        wr_n_d      = 1'b1;
        rd_n_d      = 1'b1;
        addr_d      = addr_q;
        din_d       = din_q;
        vid_dout_d  = vid_dout_q;
        vid_valid_d = 1'b0;
        cpu_dout_d  = cpu_dout_q;
        cpu_ack_d   = 1'b0;

        case (ph_nxt_s)
            3'd0: begin
                addr_d = preview_row_s;
            end
            3'd1: begin
                addr_d  = row_d;
                ras_n_d = 1'b0;
            end
            3'd2, 3'd3, 3'd4, 3'd5: begin
                ras_n_d = 1'b0;
                if (slot_d == SLOT_REF) begin
                    addr_d = row_d;
                end else begin
                    addr_d  = col_addr_s;
                    cas_n_d = 1'b0;
                end
                if (ph_nxt_s == 3'd4) begin
                    case (slot_d)
                        SLOT_VID, SLOT_CPU_RD: rd_n_d = 1'b0;
                        SLOT_CPU_WR: begin
                            wr_n_d = 1'b0;
                            din_d  = wdat_d;
                        end
                        default: rd_n_d = 1'b1;
                    endcase
                end else begin
                    rd_n_d = 1'b1;
                end
            end
            default: begin
                ras_n_d = 1'b1;
            end
        endcase

        // DRAM output is registered, so read data is valid during PH5
        if (ph_cur_s == 3'd5) begin
            case (slot_q)
                SLOT_VID: begin
                    vid_dout_d  = bus.dram_dout;
                    vid_valid_d = 1'b1;
                end
                SLOT_CPU_RD: begin
                    cpu_dout_d = bus.dram_dout;
                    cpu_ack_d  = 1'b1;
                end
                SLOT_CPU_WR: cpu_ack_d = 1'b1;
                default:     cpu_ack_d = 1'b0;
            endcase
        end else begin
            cpu_ack_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge mclk_i) begin
        if (rst_i) begin
            cnt_q       <= 4'd0;
            slot_q      <= SLOT_VID;
            row_q       <= 8'd0;
            col_q       <= 6'd0;
            wdat_q      <= 4'd0;
            streak_q    <= '0;
            ref_row_q   <= 8'd0;
            ras_n_q     <= 1'b1;
            cas_n_q     <= 1'b1;
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            addr_q      <= 8'd0;
            din_q       <= 4'd0;
            vid_dout_q  <= 4'd0;
            vid_valid_q <= 1'b0;
            cpu_dout_q  <= 4'd0;
            cpu_ack_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wdat_q      <= wdat_d;
            streak_q    <= streak_d;
            ref_row_q   <= ref_row_d;
            ras_n_q     <= ras_n_d;
            cas_n_q     <= cas_n_d;
            wr_n_q      <= wr_n_d;
            rd_n_q      <= rd_n_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            vid_dout_q  <= vid_dout_d;
            vid_valid_q <= vid_valid_d;
            cpu_dout_q  <= cpu_dout_d;
            cpu_ack_q   <= cpu_ack_d;
        end
    end

    assign bus.ras_n     = ras_n_q;
    assign bus.cas_n     = cas_n_q;
    assign bus.wr_n      = wr_n_q;
    assign bus.rd_n      = rd_n_q;
    assign bus.dram_addr = addr_q;
    assign bus.dram_din  = din_q;
    assign bus.vid_dout  = vid_dout_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.cpu_dout  = cpu_dout_q;
    assign bus.cpu_ack   = cpu_ack_q;

endmodule

// File: tb/tb_charram_dram_sequencer.sv
// Bench for charram_dram_sequencer: behavioural 4416 model plus a frame-level reference
// that predicts every strobe, address and data output from the slot/streak/refresh rules.
module tb_charram_dram_sequencer;
    logic mclk = 1'b0;
    logic rst;

    charram_dram_sequencer_if bus();

    charram_dram_sequencer #(.REFRESH_MAX(16)) dut (
        .mclk_i (mclk),
        .rst_i  (rst),
        .bus    (bus)
    );

    always #5 mclk = ~mclk;

    // DRAM array: row latched on RAS fall, column from addr[6:1] while CAS is low
    logic [3:0] dram_mem [0:16383];
    logic [3:0] ref_mem  [0:16383];
    logic       preloaded = 1'b0;
    logic       ras_prev  = 1'b1;
    logic [7:0] d_row     = 8'd0;
    logic [3:0] d_dout    = 4'd0;

    assign bus.dram_dout = d_dout;

    always @(posedge mclk) begin
        if (!preloaded) begin
            for (int i = 0; i < 16384; i++) dram_mem[i] <= ref_mem[i];
            preloaded <= 1'b1;
        end
        ras_prev <= bus.ras_n;
        if (!bus.ras_n && ras_prev) d_row <= bus.dram_addr;
        if (!bus.cas_n) begin
            if (!bus.wr_n) dram_mem[{bus.dram_addr[6:1], d_row}] <= bus.dram_din;
            if (!bus.rd_n) d_dout <= dram_mem[{bus.dram_addr[6:1], d_row}];
        end
    end

    int checks = 0;
    int errors = 0;
    int ph     = 0;
    int cyc    = 0;

    // reference model state
    int          streak;
    logic [7:0]  ref_row;
    logic [3:0]  exp_vdout, exp_cdout;
    int          kind;            // 0 refresh, 1 cpu read, 2 cpu write
    logic [13:0] v_addr, c_addr;
    logic [3:0]  c_din;
    logic [7:0]  rrow;
    int          samp_cyc, last_lat, acks_seen, refs_seen, vid_seen;
    logic [7:0]  last_rrow;
    bit          rand_mode = 1'b0;

    task automatic step();
        logic r;
        r = rst;
        @(posedge mclk);
        #1;
        cyc++;
        ph = r ? 0 : (ph + 1) % 16;
    endtask

    task automatic model_reset();
        streak    = 0;
        ref_row   = 8'd0;
        exp_vdout = 4'd0;
        exp_cdout = 4'd0;
        kind      = 0;
        acks_seen = 0;
        refs_seen = 0;
        vid_seen  = 0;
        last_lat  = -1;
        last_rrow = 8'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic randomize_inputs();
        bus.vid_addr = 14'($urandom);
        bus.cpu_req  = ($urandom_range(0, 3) != 0);
        bus.cpu_wr   = 1'($urandom);
        bus.cpu_addr = 14'($urandom);
        bus.cpu_din  = 4'($urandom);
    endtask

    // Runs whole frames from PH0 of half 0, predicting every cycle's outputs
    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < 16; c++) begin
                int         p;
                bit         h;
                bit         refr;
                logic [3:0] exp_strb;
                logic [7:0] exp_addr;
                p = c % 8;
                h = (c >= 8);
                if (c == 0) v_addr = bus.vid_addr;
                if (c == 8) begin
                    if (bus.cpu_req && streak < 16) begin
                        kind     = bus.cpu_wr ? 2 : 1;
                        c_addr   = bus.cpu_addr;
                        c_din    = bus.cpu_din;
                        streak   = streak + 1;
                        samp_cyc = cyc;
                    end else begin
                        kind   = 0;
                        rrow   = ref_row;
                        streak = 0;
                    end
                end
                refr = h && (kind == 0);
                exp_strb[3] = !(p >= 1 && p <= 5);
                exp_strb[2] = !(p >= 2 && p <= 5 && !refr);
                exp_strb[1] = !(p == 4 && h && kind == 2);
                exp_strb[0] = !(p == 4 && (!h || kind == 1));
                checks++;
                if ({bus.ras_n, bus.cas_n, bus.wr_n, bus.rd_n} !== exp_strb) begin
                    errors++;
                    $display("FAIL strobes ras/cas/wr/rd ph=%0d got %b exp %b", c,
                             {bus.ras_n, bus.cas_n, bus.wr_n, bus.rd_n}, exp_strb);
                end
                if (p >= 1 && p <= 5) begin
                    if (refr) exp_addr = rrow;
                    else if (p == 1) exp_addr = h ? c_addr[7:0] : v_addr[7:0];
                    else exp_addr = {1'b0, (h ? c_addr[13:8] : v_addr[13:8]), 1'b0};
                    checks++;
                    if (bus.dram_addr !== exp_addr) begin
                        errors++;
                        $display("FAIL dram_addr ph=%0d got %h exp %h", c, bus.dram_addr, exp_addr);
                    end
                end
                if (refr && c == 9) begin
                    refs_seen++;
                    last_rrow = bus.dram_addr;
                end
                if (c == 12 && kind == 2) begin
                    checks++;
                    if (bus.dram_din !== c_din) begin
                        errors++;
                        $display("FAIL dram_din got %h exp %h", bus.dram_din, c_din);
                    end
                    ref_mem[c_addr] = c_din;
                end
                if (c == 6) begin
                    exp_vdout = ref_mem[v_addr];
                    if (bus.vid_valid === 1'b1) vid_seen++;
                end
                checks++;
                if (bus.vid_valid !== (c == 6)) begin
                    errors++;
                    $display("FAIL vid_valid ph=%0d got %b exp %b", c, bus.vid_valid, (c == 6));
                end
                checks++;
                if (bus.vid_dout !== exp_vdout) begin
                    errors++;
                    $display("FAIL vid_dout ph=%0d got %h exp %h", c, bus.vid_dout, exp_vdout);
                end
                if (c == 14) begin
                    if (kind == 1) exp_cdout = ref_mem[c_addr];
                    if (kind == 0) ref_row = ref_row + 8'd1;
                end
                if (h && bus.cpu_ack === 1'b1) begin
                    acks_seen++;
                    last_lat = cyc - samp_cyc;
                end
                checks++;
                if (bus.cpu_ack !== (c == 14 && kind != 0)) begin
                    errors++;
                    $display("FAIL cpu_ack ph=%0d got %b exp %b", c, bus.cpu_ack, (c == 14 && kind != 0));
                end
                checks++;
                if (bus.cpu_dout !== exp_cdout) begin
                    errors++;
                    $display("FAIL cpu_dout ph=%0d got %h exp %h", c, bus.cpu_dout, exp_cdout);
                end
                if (rand_mode && (c == 3 || c == 11)) randomize_inputs();
                step();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if ({bus.ras_n, bus.cas_n, bus.wr_n, bus.rd_n} !== 4'hF) begin
            errors++; $display("FAIL reset_strobes got %b exp 1111", {bus.ras_n, bus.cas_n, bus.wr_n, bus.rd_n});
        end
        checks++;
        if (bus.dram_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", bus.dram_addr); end
        checks++;
        if (bus.dram_din !== 4'h0) begin errors++; $display("FAIL reset_din got %h exp 0", bus.dram_din); end
        checks++;
        if (bus.vid_dout !== 4'h0) begin errors++; $display("FAIL reset_vid_dout got %h exp 0", bus.vid_dout); end
        checks++;
        if (bus.cpu_dout !== 4'h0) begin errors++; $display("FAIL reset_cpu_dout got %h exp 0", bus.cpu_dout); end
        checks++;
        if (bus.vid_valid !== 1'b0) begin errors++; $display("FAIL reset_vid_valid got %b exp 0", bus.vid_valid); end
        checks++;
        if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack got %b exp 0", bus.cpu_ack); end
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_video_idle();
        bus.cpu_req  = 1'b0;
        bus.vid_addr = 14'h2A55;
        run_frames(3);
        checks++;
        if (refs_seen !== 3) begin errors++; $display("FAIL idle_refresh_count got %0d exp 3", refs_seen); end
        checks++;
        if (last_rrow !== 8'h02) begin errors++; $display("FAIL idle_refresh_row got %h exp 02", last_rrow); end
        checks++;
        if (vid_seen !== 3) begin errors++; $display("FAIL idle_vid_valid_count got %0d exp 3", vid_seen); end
    endtask

    task automatic test_cpu_write_read();
        do_reset();
        bus.vid_addr = 14'($urandom);
        bus.cpu_req  = 1'b1;
        bus.cpu_wr   = 1'b1;
        bus.cpu_addr = 14'h0103;
        bus.cpu_din  = 4'hA;
        run_frames(1);
        bus.cpu_wr   = 1'b0;
        bus.cpu_din  = 4'h0;
        run_frames(1);
        bus.cpu_req  = 1'b0;
        checks++;
        if (bus.cpu_dout !== 4'hA) begin errors++; $display("FAIL wr_rd_data got %h exp a", bus.cpu_dout); end
        checks++;
        if (last_lat !== 6) begin errors++; $display("FAIL cpu_latency got %0d exp 6", last_lat); end
        checks++;
        if (acks_seen !== 2) begin errors++; $display("FAIL wr_rd_ack_count got %0d exp 2", acks_seen); end
    endtask

    task automatic test_streak();
        do_reset();
        bus.cpu_req  = 1'b1;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 14'($urandom);
        run_frames(18);
        bus.cpu_req  = 1'b0;
        checks++;
        if (acks_seen !== 17) begin errors++; $display("FAIL streak_ack_count got %0d exp 17", acks_seen); end
        checks++;
        if (refs_seen !== 1) begin errors++; $display("FAIL streak_refresh_count got %0d exp 1", refs_seen); end
        checks++;
        if (last_rrow !== 8'h00) begin errors++; $display("FAIL streak_refresh_row got %h exp 00", last_rrow); end
    endtask

    task automatic test_random_mix();
        do_reset();
        rand_mode = 1'b1;
        randomize_inputs();
        run_frames(24);
        rand_mode = 1'b0;
        bus.cpu_req = 1'b0;
        checks++;
        if (vid_seen !== 24) begin errors++; $display("FAIL mix_vid_valid_count got %0d exp 24", vid_seen); end
    endtask

    task automatic test_reset_midwrite();
        logic [13:0] x;
        logic [3:0]  orig;
        do_reset();
        x    = 14'($urandom);
        orig = ref_mem[x];
        bus.cpu_req  = 1'b1;
        bus.cpu_wr   = 1'b1;
        bus.cpu_addr = x;
        bus.cpu_din  = orig ^ 4'hF;
        for (int i = 0; i < 11; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if ({bus.ras_n, bus.cas_n, bus.wr_n, bus.rd_n} !== 4'hF) begin
            errors++; $display("FAIL midreset_strobes got %b exp 1111", {bus.ras_n, bus.cas_n, bus.wr_n, bus.rd_n});
        end
        checks++;
        if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL midreset_ack got %b exp 0", bus.cpu_ack); end
        step();
        checks++;
        if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL midreset_ack2 got %b exp 0", bus.cpu_ack); end
        rst = 1'b0;
        bus.cpu_req = 1'b0;
        model_reset();
        run_frames(1);
        checks++;
        if (dram_mem[x] !== orig) begin errors++; $display("FAIL midreset_ram got %h exp %h", dram_mem[x], orig); end
        bus.cpu_req = 1'b1;
        bus.cpu_wr  = 1'b0;
        run_frames(1);
        bus.cpu_req = 1'b0;
        checks++;
        if (bus.cpu_dout !== orig) begin errors++; $display("FAIL midreset_readback got %h exp %h", bus.cpu_dout, orig); end
    endtask

    task automatic test_refresh_wrap();
        do_reset();
        bus.cpu_req = 1'b0;
        run_frames(256);
        checks++;
        if (last_rrow !== 8'hFF) begin errors++; $display("FAIL wrap_row_ff got %h exp ff", last_rrow); end
        run_frames(1);
        checks++;
        if (last_rrow !== 8'h00) begin errors++; $display("FAIL wrap_row_00 got %h exp 00", last_rrow); end
        checks++;
        if (refs_seen !== 257) begin errors++; $display("FAIL wrap_refresh_count got %0d exp 257", refs_seen); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.vid_addr = 14'h0000;
        bus.cpu_req  = 1'b0;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 14'h0000;
        bus.cpu_din  = 4'h0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 4'($urandom);
        ref_mem[14'h0103] = 4'h5;
        model_reset();

        test_reset();
        test_video_idle();
        test_cpu_write_read();
        test_streak();
        test_random_mix();
        test_reset_midwrite();
        test_refresh_wrap();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
